gate_char_sequencer: RTL
========================

// Module: gate_char_sequencer
// PURPOSE
//  Sequencer that characterises the 4-input switch-level CMOS gate (inputs a,b,c,d; output w).
//  Walks all 16 input vectors, waits for w to settle, and checks w against the golden function
//  w = d ? ~(a&b) : ~c. Reports mismatch count, worst-case settle latency and first failing vector.
//  Sits between the bench/top-level control and one gate instance.
// PARAMETERS
//  SETTLE_CYC   2   consecutive matching samples of w required to declare a vector settled (>=1)
//  TIMEOUT_CYC  15  WAIT cycles allowed per vector before it is declared failed (> SETTLE_CYC)
//  CNT_W        5   width of latency/wait counters; must hold TIMEOUT_CYC
// PORTS
//  clk            in   1      single clock; all state updates on posedge
//  rst_n          in   1      synchronous, active-low reset
//  start          in   1      begin a 16-vector sweep; sampled only in IDLE
//  w_i            in   1      gate output under test (asynchronous to clk; registered internally)
//  vec_o          out  4      gate inputs {a,b,c,d} = vec_o[3:0]
//  busy           out  1      high from the cycle after start is accepted until DONE is exited
//  done           out  1      one-cycle pulse at end of sweep
//  err_cnt        out  5      vectors failed in last sweep (0..16)
//  max_lat        out  CNT_W  worst settle latency over passing vectors
//  first_fail_vec out  4      vec_o value of first failing vector
//  first_fail_vld out  1      first_fail_vec is valid
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; vec_o=0, busy=0, done=0, err_cnt=0, max_lat=0,
//   first_fail_vec=0, first_fail_vld=0, internal w_q=0. Reset mid-sweep aborts immediately, same values.
//  States: IDLE -> APPLY -> WAIT -> CHECK -> NEXT -> (APPLY | DONE) -> IDLE.
//  IDLE: start=1 -> APPLY; idx=0; err_cnt, max_lat, first_fail_* cleared. start ignored elsewhere.
//  APPLY (1 cycle): vec_o = order(idx), registered on entry; wait_cnt=0, run=0.
//  w_q <= w_i every cycle. WAIT: each cycle compare w_q with golden(vec_o):
//   match: run++, on run 0->1 latch lat=wait_cnt; mismatch: run=0.
//   pass when run reaches SETTLE_CYC; fail when wait_cnt==TIMEOUT_CYC-1 without pass.
//   Pass and timeout in same cycle -> pass wins. Either exits to CHECK; else wait_cnt++.
//  Zero-delay gate: lat=0; gate delayed N clk -> lat=N.
//  CHECK (1 cycle): pass -> max_lat=max(max_lat,lat). fail -> err_cnt++; if !first_fail_vld,
//   capture first_fail_vec=vec_o, set first_fail_vld. Failed vectors do not touch max_lat.
//  NEXT: idx==15 -> DONE, else idx++ -> APPLY. idx is 4-bit, no wrap past 15.
//  DONE (1 cycle): done=1, busy=0 from next cycle; -> IDLE. Results hold until next accepted start.
//  vec_o holds last vector in IDLE after a sweep.
//  Timing: zero-delay good gate -> done high in the cycle starting 16*(3+SETTLE_CYC) edges after
//   the edge accepting start (80 for SETTLE_CYC=2).
// CONFIGURATION
//  GATE_CHAR_GRAY_ORDER_EN defined: order(idx)=idx^(idx>>1) (Gray; one input toggles per step).
//  Undefined: order(idx)=idx (binary). All other behaviour identical; err_cnt independent of order.
// STRUCTURE
//  Package gate_char_pkg: state_t enum (IDLE,APPLY,WAIT,CHECK,NEXT,DONE); function golden(vec[3:0]);
//   function order(idx[3:0]) with the macro switch; localparam NUM_VEC=16.
//  Sub-module gate_char_watch: w_q register, wait_cnt/run counters, lat latch, pass/timeout outputs;
//   cleared by a restart input from the FSM in APPLY.
// TESTING
//  Behavioural zero-delay correct gate, SETTLE_CYC=2 -> err_cnt=0, max_lat=0, first_fail_vld=0, done at cycle 80.
//  w_i stuck at 0 -> err_cnt=10, first_fail_vec=4'b0000, first_fail_vld=1.
//  w_i stuck at 1 -> err_cnt=6, first_fail_vec=4'b0010 (both orders).
//  Correct gate delayed 3 clk -> err_cnt=0, max_lat=3; delayed 20 clk -> err_cnt=16 via timeout.
//  Switch-level gate instance, 20 ns clk -> err_cnt=0, max_lat<=1.
//  rst_n low during WAIT of vector 7 -> all outputs to reset values next edge; new start runs full sweep.

Source files
------------

// File: rtl/gate_char_pkg.sv
// Shared types and helpers for the gate characterisation sequencer.
// GATE_CHAR_GRAY_ORDER_EN selects Gray-code vector order; binary order otherwise.
package gate_char_pkg;

  localparam int NUM_VEC = 16;

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, NEXT, DONE} state_t;

  // vec = {a,b,c,d}; w = d ? ~(a&b) : ~c
  function automatic logic golden(input logic [3:0] vec);
    return vec[0] ? ~(vec[3] & vec[2]) : ~vec[1];
  endfunction

  function automatic logic [3:0] order(input logic [3:0] idx);
`ifdef GATE_CHAR_GRAY_ORDER_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/gate_char_watch.sv
// Settle watcher: registers the gate output, counts wait cycles and consecutive
// matches, latches the first-match latency and flags pass or timeout.
module gate_char_watch #(
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             active,
  input  logic             w_i,
  input  logic             expect_w,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] lat
);

  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] LAST_V   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_q;
  logic             match;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] run;

  // pass takes priority when the settle run completes on the last allowed cycle
  always_comb begin
    match   = (w_q == expect_w);
    pass    = active && match && ((run + ONE) == SETTLE_V);
    timeout = active && !pass && (wait_cnt == LAST_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q      <= 1'b0;
      wait_cnt <= '0;
      run      <= '0;
      lat      <= '0;
    end else begin
      w_q <= w_i;
      if (restart) begin
        wait_cnt <= '0;
        run      <= '0;
        lat      <= '0;
      end else if (active) begin
        run <= match ? run + ONE : '0;
        if (match && run == '0)
          lat <= wait_cnt;
        if (!(pass || timeout))
          wait_cnt <= wait_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/gate_char_sequencer.sv
// Sweeps all 16 input vectors of the 4-input gate, checks each settled output
// against the golden function and reports errors, worst latency and first failure.
// Vector order is Gray when GATE_CHAR_GRAY_ORDER_EN is defined, binary otherwise.
module gate_char_sequencer
  import gate_char_pkg::*;
#(
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             w_i,
  output logic [3:0]       vec_o,
  output logic             busy,
  output logic             done,
  output logic [4:0]       err_cnt,
  output logic [CNT_W-1:0] max_lat,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_vld
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

  state_t           state, state_nxt;
  logic [3:0]       idx;
  logic             pass_q;
  logic             restart, active;
  logic             pass, timeout;
  logic [CNT_W-1:0] lat;

  gate_char_watch #(
    .SETTLE_CYC (SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_watch (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .active  (active),
    .w_i     (w_i),
    .expect_w(golden(vec_o)),
    .pass    (pass),
    .timeout (timeout),
    .lat     (lat)
  );

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    restart   = (state == APPLY);
    active    = (state == WAIT);
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   state_nxt = WAIT;
      WAIT:    if (pass || timeout) state_nxt = CHECK;
      CHECK:   state_nxt = NEXT;
      NEXT:    state_nxt = (idx == LAST_IDX) ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      vec_o          <= '0;
      pass_q         <= 1'b0;
      err_cnt        <= '0;
      max_lat        <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          idx            <= '0;
          vec_o          <= order(4'd0);
          err_cnt        <= '0;
          max_lat        <= '0;
          first_fail_vec <= '0;
          first_fail_vld <= 1'b0;
        end
        WAIT: if (pass || timeout) pass_q <= pass;
        CHECK: begin
          if (pass_q) begin
            if (lat > max_lat) max_lat <= lat;
          end else begin
            err_cnt <= err_cnt + 5'd1;
            if (!first_fail_vld) begin
              first_fail_vec <= vec_o;
              first_fail_vld <= 1'b1;
            end
          end
        end
        // vec_o is loaded together with idx so it is valid throughout APPLY
        NEXT: if (idx != LAST_IDX) begin
          idx   <= idx + 4'd1;
          vec_o <= order(idx + 4'd1);
        end
        default: ;
      endcase
    end
  end

endmodule
